// File: rtl/bp_resolve_ctrl.sv
// bp_resolve_ctrl: branch-resolution controller.
// Records each fetch-time prediction in an in-order prediction queue (PQ).
// As each instruction resolves in EX, compares the actual next PC with the
// predicted next PC. Drives predictor update/flush strobes, the PC redirect,
// and a fetch freeze while the pipeline drains after a misprediction.
//
// Ports
//   CLK, RSTN                    clock (rising edge), async active-low reset
//   if_vld/if_pc/if_bp_taken/if_bp_pc
//                                fetch-side prediction to enqueue
//   ex_vld/ex_pc/ex_branch/ex_call/ex_return/ex_taken/ex_target
//                                resolution of the oldest in-flight instruction
//   alu_*                        predictor update strobes and data (registered)
//   redirect_vld/redirect_pc     one-cycle PC redirect after a misprediction
//   pc_freeze                    hold fetch (flushing or queue full)
//   pq_full/pq_empty             queue status after the current edge
//   pq_err                       sticky protocol error
//   br_cnt/miss_cnt              saturating branch / misprediction counters
module bp_resolve_ctrl #(
  parameter int unsigned PQ_DEPTH     = 4,
  parameter int unsigned PQ_AW        = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        if_vld,
  input  logic [31:0] if_pc,
  input  logic        if_bp_taken,
  input  logic [31:0] if_bp_pc,
  input  logic        ex_vld,
  input  logic [31:0] ex_pc,
  input  logic        ex_branch,
  input  logic        ex_call,
  input  logic        ex_return,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        alu_branch,
  output logic        alu_call,
  output logic        alu_return,
  output logic        alu_taken,
  output logic        alu_flush,
  output logic [31:0] alu_pc,
  output logic [31:0] alu_target,
  output logic        redirect_vld,
  output logic [31:0] redirect_pc,
  output logic        pc_freeze,
  output logic        pq_full,
  output logic        pq_empty,
  output logic        pq_err,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e           state, state_d;
  logic [15:0]      cnt, cnt_d;
  logic [PQ_AW-1:0] wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
  logic [PQ_AW:0]   count, count_d;

  logic [31:0] pq_pc      [PQ_DEPTH];
  logic        pq_taken   [PQ_DEPTH];
  logic [31:0] pq_pred_pc [PQ_DEPTH];

  logic        is_run, push, ex_req, pop, mispredict, br_pop;
  logic [31:0] head_pc, pred_next, act_next;

  assign is_run  = (state == StRun);
  // pc_freeze is the registered output; in RUN it equals the current full flag.
  assign push    = if_vld & ~pc_freeze & is_run;
  assign ex_req  = ex_vld & is_run;
  assign pop     = ex_req & ~pq_empty;
  assign br_pop  = pop & ex_branch;

  assign head_pc    = pq_pc[rd_ptr];
  assign pred_next  = pq_taken[rd_ptr] ? pq_pred_pc[rd_ptr] : head_pc + 32'd4;
  assign act_next   = (ex_branch & ex_taken) ? ex_target : ex_pc + 32'd4;
  assign mispredict = pop & (pred_next != act_next);

  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    count_d  = count;
    if (mispredict) begin
      // Drop the whole queue, including any push arriving this cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr + 1'b1;
      if (push & ~pop)      count_d = count + 1'b1;
      else if (pop & ~push) count_d = count - 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      StRun: begin
        if (mispredict) begin
          state_d = StFlush;
          cnt_d   = 16'(FLUSH_CYCLES - 1);
        end
      end
      StFlush: begin
        if (cnt == '0) state_d = StRun;
        else           cnt_d   = cnt - 16'd1;
      end
      default: state_d = StRun;
    endcase
  end

  // Queue storage needs no reset: entries are only read while count > 0.
  always_ff @(posedge CLK) begin
    if (push & ~mispredict) begin
      pq_pc[wr_ptr]      <= if_pc;
      pq_taken[wr_ptr]   <= if_bp_taken;
      pq_pred_pc[wr_ptr] <= if_bp_pc;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state        <= StRun;
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      alu_branch   <= 1'b0;
      alu_call     <= 1'b0;
      alu_return   <= 1'b0;
      alu_taken    <= 1'b0;
      alu_flush    <= 1'b0;
      alu_pc       <= '0;
      alu_target   <= '0;
      redirect_vld <= 1'b0;
      redirect_pc  <= '0;
      pc_freeze    <= 1'b0;
      pq_full      <= 1'b0;
      pq_empty     <= 1'b1;
      pq_err       <= 1'b0;
      br_cnt       <= '0;
      miss_cnt     <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      count      <= count_d;
      pq_full    <= (count_d == (PQ_AW+1)'(PQ_DEPTH));
      pq_empty   <= (count_d == '0);
      pc_freeze  <= (state_d == StFlush) | (count_d == (PQ_AW+1)'(PQ_DEPTH));
      // Update strobes pulse for one cycle; only branch pops update the data.
      alu_branch <= br_pop;
      alu_call   <= br_pop & ex_call;
      alu_return <= br_pop & ex_return;
      alu_taken  <= br_pop & ex_taken;
      if (br_pop) begin
        alu_pc     <= ex_pc;
        alu_target <= ex_target;
      end
      alu_flush    <= mispredict;
      redirect_vld <= mispredict;
      if (mispredict) redirect_pc <= act_next;
      if ((ex_req & pq_empty) | (pop & (ex_pc != head_pc))) pq_err <= 1'b1;
      if (br_pop & (br_cnt != '1))     br_cnt   <= br_cnt + 32'd1;
      if (mispredict & (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: doc/bp_resolve_ctrl.md
# bp_resolve_ctrl

Branch-resolution controller between the fetch stage, the EX/ALU stage and the branch predictor. It records every fetch-time prediction in an in-order prediction queue. When an instruction resolves in EX, it compares the actual next PC with the predicted one. It then drives the predictor update and flush strobes, the PC redirect, and a fetch freeze while the pipeline drains after a misprediction.

## Interface
- PQ_DEPTH, 4: prediction-queue entries (power of two, ≥2)
- PQ_AW, 2: log2(PQ_DEPTH)
- FLUSH_CYCLES, 2: freeze cycles after a misprediction (≥1)

- CLK  in  1  clock, rising edge
- RSTN  in  1  reset; one clock, asynchronous, active-low
- if_vld  in  1  fetch presents an instruction
- if_pc  in  32  fetched PC
- if_bp_taken  in  1  predictor said taken
- if_bp_pc  in  32  predicted target
- ex_vld  in  1  oldest in-flight instruction resolves in EX this cycle
- ex_pc  in  32  resolved PC
- ex_branch / ex_call / ex_return / ex_taken  in  1 each  resolved control-flow attributes
- ex_target  in  32  resolved target
- alu_branch, alu_call, alu_return, alu_taken, alu_flush  out  1 each  predictor update strobes
- alu_pc, alu_target  out  32 each  predictor update data
- redirect_vld  out  1  PC must load redirect_pc; overrides pc_freeze
- redirect_pc  out  32  correct next PC
- pc_freeze  out  1  hold fetch
- pq_full, pq_empty  out  1 each  queue status
- pq_err  out  1  sticky protocol error
- br_cnt, miss_cnt  out  32 each  resolved-branch and misprediction counters

## Operation
- **Queue entry:** {pc, pred_taken, pred_pc}. Circular buffer with PQ_AW-bit rd/wr pointers and a (PQ_AW+1)-bit count.
- **Push:** if_vld & ~pc_freeze & state==RUN.
- **Pop:** ex_vld & state==RUN & ~pq_empty.
- **Simultaneous push and pop** (non-mispredicting): both happen; count is unchanged.
- **Predicted next PC:** pred_taken ? pred_pc : pc+4.
- **Actual next PC:** (ex_branch & ex_taken) ? ex_target : ex_pc+4. Arithmetic is 32-bit modulo.
- **Mispredict** = pop & (predicted next PC ≠ actual next PC).
- **FSM RUN:**
  - On mispredict: go to FLUSH and load cnt = FLUSH_CYCLES-1.
  - Clear the queue (pointers and count to 0). Any same-cycle push is dropped.
- **FSM FLUSH:**
  - No push, no pop. ex_vld and if_vld are ignored and do not set pq_err.
  - cnt decrements each cycle; when cnt==0, go to RUN.
- **pc_freeze** = (state==FLUSH) | pq_full.
- **pq_err** is set (sticky until reset) by either of:
  - ex_vld in RUN while pq_empty; no pop and no update occurs.
  - pop with ex_pc ≠ entry pc; the pop and update still proceed.
- **Counters:**
  - br_cnt increments on pop & ex_branch.
  - miss_cnt increments on mispredict.
  - Both saturate at 0xFFFF_FFFF.
- **Reset** (asynchronous, valid mid-operation): state RUN, queue empty, all outputs 0 except pq_empty=1. Counters and pq_err clear.

## Timing
- All outputs are registered.
- **Predictor update, cycle N+1 after a pop in cycle N:**
  - alu_branch = ex_branch of the popped instruction; alu_call, alu_return, alu_taken, alu_pc, alu_target are copied from the EX inputs.
  - Non-branch pops produce alu_branch=0 and leave the data outputs held.
- **Misprediction in cycle N, at cycle N+1:**
  - alu_flush=1 and redirect_vld=1 for exactly one cycle; redirect_pc = actual next PC.
  - pc_freeze=1 for exactly FLUSH_CYCLES cycles (N+1 .. N+FLUSH_CYCLES).
  - First push is accepted in cycle N+FLUSH_CYCLES+1.
- pq_full and pq_empty reflect the count after the current edge. pc_freeze from a full queue drops the cycle after a pop.
- Counters update at N+1.

## Test plan
- **Correct not-taken:** push {pc=0x100, taken=0} then pop with ex_branch=1, ex_taken=0, ex_pc=0x100 -> next cycle alu_branch=1, alu_taken=0, alu_flush=0, br_cnt=1, miss_cnt=0.
- **Mispredict:** push {0x200, taken=1, pred_pc=0x400} plus 2 more entries; pop with ex_taken=0 -> alu_flush=1 and redirect_vld=1 with redirect_pc=0x204 for 1 cycle; pc_freeze high for 2 cycles; pq_empty=1; miss_cnt=1; if_vld during freeze pushes nothing.
- **Full and concurrency:** 4 pushes -> pq_full=1, pc_freeze=1, 5th if_vld dropped; a pop releases pc_freeze next cycle; simultaneous push and pop at count 2 keeps count 2.
- **Protocol error:** ex_vld on an empty queue -> pq_err=1 stays set, no alu_branch; pop with ex_pc=0x300 against entry pc 0x304 -> pq_err=1 and the update still issues.
- **Reset mid-FLUSH:** assert RSTN=0 during the freeze -> immediately pc_freeze=0, pq_empty=1, counters 0, state RUN; after release, the first if_vld is accepted.
- **Counter saturation:** force br_cnt to 0xFFFF_FFFE, resolve 3 branches -> br_cnt = 0xFFFF_FFFF.
